// File: rtl/div_unit.sv
// ============================================================================
// div_unit - multi-cycle radix-2 restoring divider (MIPS DIV / DIVU)
//
// Produces {remainder, quotient} for the HI/LO registers.
//
// Ports
//   i_clk           clock, rising edge
//   i_rst           synchronous reset, active-high
//   i_start         request a divide (sampled only in IDLE)
//   i_signed_div    1 = DIV (two's complement), 0 = DIVU (sampled with start)
//   i_a             dividend (sampled with start)
//   i_b             divisor  (sampled with start)
//   i_cancel        abort current operation, return to IDLE at next edge
//   o_busy          high in CALC and DONE
//   o_result_valid  one-cycle pulse when o_result takes a new value
//   o_result        {remainder[2N-1:N], quotient[N-1:0]}, held until next DONE
//
// Handshake: a request is accepted on the rising edge where i_start=1,
// i_cancel=0 and the unit is IDLE (o_busy=0). Starts seen while busy are
// dropped. Each accepted and not cancelled request produces exactly one
// o_result_valid pulse.
//
// Configuration macro
//   DIV_EARLY_OUT_EN : when defined, a divisor whose magnitude exceeds the
//                      dividend's magnitude skips the iteration and finishes
//                      with q=0, r=a, one edge after the start edge.
// ============================================================================
module div_unit #(
    parameter int N = 32
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_start,
    input  logic           i_signed_div,
    input  logic [N-1:0]   i_a,
    input  logic [N-1:0]   i_b,
    input  logic           i_cancel,
    output logic           o_busy,
    output logic           o_result_valid,
    output logic [2*N-1:0] o_result
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_rem;     // partial remainder
    logic [N-1:0]   r_quo;     // dividend shifts out the top, quotient bits in
    logic [N-1:0]   r_div;     // divisor magnitude
    logic           r_neg_q;
    logic           r_neg_r;
    logic           r_valid;
    logic [2*N-1:0] r_result;

    // Operand magnitudes; only meaningful in IDLE while i_start is sampled.
    logic         w_a_neg;
    logic         w_b_neg;
    logic [N-1:0] w_abs_a;
    logic [N-1:0] w_abs_b;
    logic         w_div_zero;
    logic         w_early;

    assign w_a_neg    = i_signed_div & i_a[N-1];
    assign w_b_neg    = i_signed_div & i_b[N-1];
    assign w_abs_a    = w_a_neg ? (~i_a + 1'b1) : i_a;
    assign w_abs_b    = w_b_neg ? (~i_b + 1'b1) : i_b;
    assign w_div_zero = (i_b == '0);

`ifdef DIV_EARLY_OUT_EN
    assign w_early = (w_abs_b > w_abs_a);
`else
    assign w_early = 1'b0;
`endif

    // One restoring step. The shifted remainder needs N+1 bits; when it is
    // at least the divisor, the difference is below the divisor and fits
    // back into N bits, so modulo-2^N subtraction is exact.
    logic [N:0]   w_shift;
    logic         w_ge;
    logic [N-1:0] w_sub;

    assign w_shift = {r_rem, r_quo[N-1]};
    assign w_ge    = (w_shift >= {1'b0, r_div});
    assign w_sub   = w_shift[N-1:0] - r_div;

    // Sign fix applied when the result is written.
    logic [N-1:0] w_q_fix;
    logic [N-1:0] w_r_fix;

    assign w_q_fix = r_neg_q ? (~r_quo + 1'b1) : r_quo;
    assign w_r_fix = r_neg_r ? (~r_rem + 1'b1) : r_rem;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state (cancel wins over everything but reset)
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (i_cancel) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        w_state_nxt = (w_div_zero || w_early) ? S_DONE : S_CALC;
                    end
                end
                S_CALC: begin
                    if (r_cnt == LAST_STEP) begin
                        w_state_nxt = S_DONE;
                    end
                end
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        o_busy = (r_state != S_IDLE);
    end

    assign o_result_valid = r_valid;
    assign o_result       = r_result;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_valid  <= 1'b0;
            r_result <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start && !i_cancel) begin
                        r_cnt   <= '0;
                        r_div   <= w_abs_b;
                        r_neg_r <= w_a_neg;
                        if (w_div_zero) begin
                            // q = all ones, r = a (sign restored at DONE)
                            r_quo   <= '1;
                            r_rem   <= w_abs_a;
                            r_neg_q <= 1'b0;
                        end else if (w_early) begin
                            r_quo   <= '0;
                            r_rem   <= w_abs_a;
                            r_neg_q <= 1'b0;
                        end else begin
                            r_quo   <= w_abs_a;
                            r_rem   <= '0;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                        end
                    end
                end
                S_CALC: begin
                    if (!i_cancel) begin
                        r_cnt <= r_cnt + CW'(1);
                        r_quo <= {r_quo[N-2:0], w_ge};
                        r_rem <= w_ge ? w_sub : w_shift[N-1:0];
                    end
                end
                S_DONE: begin
                    if (!i_cancel) begin
                        r_result <= {w_r_fix, w_q_fix};
                        r_valid  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
